pulse_train_gen: RTL

Downstream consumer of the button debouncer. Takes the debounced, stable "button pressed" level (1 = pressed), detects its rising edge, and emits one configurable train of pulses on pulse_out. The train has N pulses, each H cycles high with L cycles low between pulses. This is the output stage of the pulse generator; pulse_out drives the board pin/LED directly.

---
 rtl/pulse_train_pkg.sv | 20 ++
 rtl/pulse_train_timer.sv | 43 ++++
 rtl/pulse_train_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pulse_train_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_train_pkg
//  Brief    : Shared types and default widths for the pulse train generator.
//  Revision : 1.0 - initial release
// ============================================================================
package pulse_train_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_NUM_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage : pulse_train_pkg
`default_nettype wire

// File: rtl/pulse_train_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_train_timer
//  Brief    : Loadable down-counter; expired_o is high while the count is 0.
//             It holds at 0 until the next load.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_train_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A load takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule : pulse_train_timer
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_train_gen
//  Brief    : On a rising edge of the debounced trigger, emits num_pulses
//             pulses of high_len cycles separated by low_len cycles. Outputs
//             are registered and decoded from the next state, so pulse_out
//             and busy rise on the same edge that first samples trig high.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  logic             trig_q;
  logic             trig_rise;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] hi_d;
  logic [CNT_W-1:0] lo_q;
  logic [CNT_W-1:0] lo_d;
  logic [NUM_W-1:0] npulse_q;
  logic [NUM_W-1:0] npulse_d;

  logic             pulse_out_q;
  logic             busy_q;
  logic             done_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_exp;

  logic [CNT_W-1:0] hi_clamp;
  logic [CNT_W-1:0] lo_clamp;

  // A zero length would otherwise underflow the period load value.
  assign hi_clamp  = (high_len == '0) ? CNT_W'(1) : high_len;
  assign lo_clamp  = (low_len  == '0) ? CNT_W'(1) : low_len;
  assign trig_rise = trig & ~trig_q;

  // Previous trigger level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig;
    end
  end

  // Next-state, config latch and period-timer control.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    npulse_d = npulse_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        // A rise with a zero pulse count is dropped entirely.
        if (trig_rise && (num_pulses != '0)) begin
          state_d  = HIGH;
          hi_d     = hi_clamp;
          lo_d     = lo_clamp;
          npulse_d = num_pulses;
          tmr_load = 1'b1;
          tmr_val  = hi_clamp - CNT_W'(1);
        end
      end
      HIGH: begin
        if (tmr_exp) begin
          if (npulse_q > NUM_W'(1)) begin
            state_d  = LOW;
            npulse_d = npulse_q - NUM_W'(1);
            tmr_load = 1'b1;
            tmr_val  = lo_q - CNT_W'(1);
          end else begin
            // Last pulse: no trailing low period.
            state_d  = FIN;
            npulse_d = '0;
          end
        end
      end
      LOW: begin
        if (tmr_exp) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = hi_q - CNT_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      npulse_q <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      npulse_q <= npulse_d;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pulse_out_q <= (state_d == HIGH);
      busy_q      <= (state_d == HIGH) || (state_d == LOW);
      done_q      <= (state_d == FIN);
    end
  end

  pulse_train_timer #(
    .CNT_W (CNT_W)
  ) u_period_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : pulse_train_gen
`default_nettype wire
